isqrt_rr_arbiter: RTL and testbench
===================================

Name: isqrt_rr_arbiter

Overview:
- Shares one external pipelined isqrt instance among N_REQ requesters.
- Each cycle, a round-robin arbiter grants at most one requester and issues its operand into the isqrt.
- A fixed-latency tag pipeline tracks the requester ID of every in-flight operand and routes each result back to the requester that issued it.
- Sits between formula/application blocks and the shared isqrt, so several clients can reuse one isqrt datapath.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- SQRT_LATENCY, 16, cycles from isqrt x_vld to y_vld; must equal the connected isqrt's latency.
- ID_W, $clog2(N_REQ) (minimum 1), requester ID width; derived, not overridden.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- req_vld  input  N_REQ  per-requester operand valid.
- req_x  input  32*N_REQ  operands; requester i occupies bits [32*i+31:32*i].
- req_rdy  output  N_REQ  one-hot grant; requester i's operand is accepted when req_vld[i] & req_rdy[i].
- sq_x_vld  output  1  to isqrt x_vld.
- sq_x  output  32  to isqrt x.
- sq_y_vld  input  1  from isqrt y_vld.
- sq_y  input  16  from isqrt y.
- rsp_vld  output  N_REQ  one-hot result valid, registered.
- rsp_id  output  ID_W  index of the requester owning the result, registered.
- rsp_y  output  16  square-root result, registered.
- err  output  1  sticky tag/isqrt valid mismatch flag.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - rr pointer = 0.
  - All tag-pipeline valid bits = 0.
  - rsp_vld = 0, rsp_id = 0, rsp_y = 0, err = 0.
- Arbitration (combinational, same cycle):
  - Search req_vld starting at pointer p, wrapping modulo N_REQ; the first set bit g wins.
  - req_rdy = one-hot(g) if |req_vld, else 0.
  - req_rdy never asserts for a requester whose req_vld is 0.
- Issue:
  - sq_x_vld = |req_vld.
  - sq_x = req_x slice g when sq_x_vld = 1. When sq_x_vld = 0, sq_x holds 0 (the isqrt must not toggle data on idle).
- Pointer update on a grant: p <= (g+1) mod N_REQ, with the wrap from N_REQ-1 to 0. No grant -> p holds.
- Fairness: a requester holding req_vld is granted within N_REQ cycles.
- Tag pipeline:
  - SQRT_LATENCY stages of {vld, id}.
  - Stage 0 loads {sq_x_vld, g}.
  - The id field of each stage is enabled only when the incoming vld = 1; vld bits always shift.
  - Tag output T aligns with isqrt output in the same cycle.
- Response register (one stage):
  - rsp_vld <= T.vld ? one-hot(T.id) : 0.
  - rsp_id and rsp_y load only when T.vld = 1 (rsp_y <= sq_y); otherwise they hold.
  - Grant-to-response latency is exactly SQRT_LATENCY+1 cycles.
  - Throughput is one result per cycle; there is no backpressure and requesters must accept results.
- Error:
  - err <= 1 on any cycle where T.vld != sq_y_vld.
  - Cleared only by rst.
  - Routing is still driven by T.vld, never by sq_y_vld.
- Simultaneous events: a new issue and a response in the same cycle are independent and both proceed.
- Reset mid-operation:
  - All in-flight tags are discarded and no rsp_vld pulses for pre-reset operands.
  - The isqrt shares rst, so err must not set after reset.
- Single-requester case: with only requester k active, it is granted every cycle (100% throughput).

Test Plan:
- Single request: N_REQ=4, SQRT_LATENCY=16, req_vld=4'b0100 and x=144 for 1 cycle -> req_rdy=4'b0100 in the same cycle; 17 cycles later rsp_vld=4'b0100, rsp_id=2, rsp_y=12 for exactly 1 cycle.
- Round robin: req_vld=4'b1111 held with x0=1, x1=4, x2=9, x3=16 -> grants 0,1,2,3,0,...; responses in that order with rsp_y 1,2,3,4,1,...; one rsp_vld per cycle with no gaps.
- Pointer wrap/skip: p=3 and req_vld=4'b0101 -> grant 0, then grant 2, then grant 0; requester 3 never granted; sq_x=0 whenever req_vld=0.
- Full rate plus max value: requester 1 alone streams 0, 0xFFFFFFFF, 0xFFFFFFFE, 65536 on consecutive cycles -> rsp_y 0, 65535, 65535, 256 on consecutive cycles, all rsp_id=1; err stays 0.
- Mismatch: substitute an isqrt model with latency 15 and issue 1 operand -> err=1 from the first mismatched cycle onward and remains 1 until rst.
- Reset mid-flight: issue 8 operands, assert rst 5 cycles later for 1 cycle -> no rsp_vld afterwards, p=0, err=0; a new request after reset returns its result in 17 cycles.

Source files
------------

// File: rtl/isqrt_rr_arbiter.sv
// isqrt_rr_arbiter
// Lets N_REQ requesters share one external pipelined isqrt. A round-robin
// arbiter issues at most one operand per cycle, a fixed-latency tag pipeline
// remembers which requester owns every in-flight operand, and a single
// response register routes each isqrt result back to its owner.
module isqrt_rr_arbiter #(
  parameter  int N_REQ        = 4,
  parameter  int SQRT_LATENCY = 16,
  localparam int ID_W         = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_vld,
  input  logic [32*N_REQ-1:0]  req_x,
  output logic [N_REQ-1:0]     req_rdy,
  output logic                 sq_x_vld,
  output logic [31:0]          sq_x,
  input  logic                 sq_y_vld,
  input  logic [15:0]          sq_y,
  output logic [N_REQ-1:0]     rsp_vld,
  output logic [ID_W-1:0]      rsp_id,
  output logic [15:0]          rsp_y,
  output logic                 err
);

  // Round-robin pointer: the requester searched first in the current cycle.
  logic [ID_W-1:0]          r_ptr;

  // Arbitration result for the current cycle.
  logic                     w_any;
  logic [ID_W-1:0]          w_grant_id;
  logic [ID_W-1:0]          w_ptr_next;

  // Tag pipeline: one {vld, id} entry per isqrt pipeline stage.
  logic [SQRT_LATENCY-1:0]  r_tag_vld;
  logic [ID_W-1:0]          r_tag_id [SQRT_LATENCY];

  // Tag leaving the pipeline, aligned with sq_y_vld / sq_y.
  logic                     w_t_vld;
  logic [ID_W-1:0]          w_t_id;
  logic [N_REQ-1:0]         w_t_onehot;

  // Response and error state.
  logic [N_REQ-1:0]         r_rsp_vld;
  logic [ID_W-1:0]          r_rsp_id;
  logic [15:0]              r_rsp_y;
  logic                     r_err;

  assign w_any = |req_vld;

  // Find the first requesting index at or after the pointer, wrapping modulo N_REQ.
  always_comb begin
    // NOTE: every variable gets a default before the search so no latch is inferred.
    w_grant_id = '0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      int idx;
      idx = int'(r_ptr) + off;
      if (idx >= N_REQ) idx = idx - N_REQ;
      // Walking from the farthest offset down lets the nearest hit win last.
      if (req_vld[idx]) w_grant_id = ID_W'(idx);
    end
  end

  // Decode the winner into a one-hot grant and steer its operand to the isqrt.
  always_comb begin
    req_rdy = '0;
    sq_x    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_any && (w_grant_id == ID_W'(i))) begin
        req_rdy[i] = 1'b1;
        sq_x       = req_x[32*i +: 32];
      end
    end
  end

  assign sq_x_vld = w_any;

  // Pointer moves just past the winner, wrapping from N_REQ-1 back to 0.
  assign w_ptr_next = (w_grant_id == ID_W'(N_REQ - 1)) ? '0 : w_grant_id + ID_W'(1);

  // Advance the round-robin pointer whenever a grant is issued.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      r_ptr <= '0;
    end else if (w_any) begin
      r_ptr <= w_ptr_next;
    end
  end

  // Shift the tag valid bits every cycle; reset discards all in-flight tags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_vld <= '0;
    end else begin
      r_tag_vld[0] <= sq_x_vld;
      for (int i = 1; i < SQRT_LATENCY; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
      end
    end
  end

  // Move tag IDs along with their valid bit; idle slots keep stale IDs.
  always_ff @(posedge clk) begin
    // NOTE: the ID array is deliberately not reset; its contents are only used under a reset-cleared valid bit.
    if (sq_x_vld) r_tag_id[0] <= w_grant_id;
    for (int i = 1; i < SQRT_LATENCY; i++) begin
      if (r_tag_vld[i-1]) r_tag_id[i] <= r_tag_id[i-1];
    end
  end

  assign w_t_vld = r_tag_vld[SQRT_LATENCY-1];
  assign w_t_id  = r_tag_id[SQRT_LATENCY-1];

  // One-hot owner of the result currently presented by the isqrt.
  always_comb begin
    w_t_onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_t_vld && (w_t_id == ID_W'(i))) w_t_onehot[i] = 1'b1;
    end
  end

  // Register the routed response; routing follows the tag, never sq_y_vld.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_vld <= '0;
      r_rsp_id  <= '0;
      r_rsp_y   <= '0;
    end else begin
      r_rsp_vld <= w_t_onehot;
      if (w_t_vld) begin
        r_rsp_id <= w_t_id;
        r_rsp_y  <= sq_y;
      end
    end
  end

  // Sticky flag for any cycle where the tag and the isqrt disagree on validity.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_t_vld != sq_y_vld) begin
      r_err <= 1'b1;
    end
  end

  assign rsp_vld = r_rsp_vld;
  assign rsp_id  = r_rsp_id;
  assign rsp_y   = r_rsp_y;
  assign err     = r_err;

endmodule

// File: tb/tb_isqrt_rr_arbiter.sv
// Directed bench for isqrt_rr_arbiter with N_REQ=4, SQRT_LATENCY=16.
// A behavioural isqrt with selectable latency (16 nominal, 15 for the
// mismatch case) stands in for the shared datapath.
module tb_isqrt_rr_arbiter;

  localparam int N = 4;
  localparam int L = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_vld = '0;
  logic [32*N-1:0] req_x = '0;
  logic [N-1:0]    req_rdy;
  logic            sq_x_vld;
  logic [31:0]     sq_x;
  logic            sq_y_vld;
  logic [15:0]     sq_y;
  logic [N-1:0]    rsp_vld;
  logic [1:0]      rsp_id;
  logic [15:0]     rsp_y;
  logic            err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int model_lat = 16;

  isqrt_rr_arbiter #(.N_REQ(N), .SQRT_LATENCY(L)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_vld  (req_vld),
    .req_x    (req_x),
    .req_rdy  (req_rdy),
    .sq_x_vld (sq_x_vld),
    .sq_x     (sq_x),
    .sq_y_vld (sq_y_vld),
    .sq_y     (sq_y),
    .rsp_vld  (rsp_vld),
    .rsp_id   (rsp_id),
    .rsp_y    (rsp_y),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Behavioural pipelined isqrt
  function automatic logic [15:0] isqrt_ref(input logic [31:0] x);
    logic [15:0] r;
    logic [15:0] t;
    r = '0;
    for (int i = 15; i >= 0; i--) begin
      t = r | (16'd1 << i);
      if ({32'd0, 16'd0, t} * {32'd0, 16'd0, t} <= {32'd0, x}) r = t;
    end
    return r;
  endfunction

  logic        m_vld [16];
  logic [15:0] m_y   [16];

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 16; k++) m_vld[k] <= 1'b0;
    end else begin
      m_vld[0] <= sq_x_vld;
      for (int k = 1; k < 16; k++) m_vld[k] <= m_vld[k-1];
    end
    m_y[0] <= isqrt_ref(sq_x);
    for (int k = 1; k < 16; k++) m_y[k] <= m_y[k-1];
  end

  assign sq_y_vld = (model_lat == 15) ? m_vld[14] : m_vld[15];
  assign sq_y     = (model_lat == 15) ? m_y[14]   : m_y[15];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance until a response appears (bounded); returns the cycle it appeared in.
  task automatic wait_rsp(input string tag, output int at);
    int n;
    n = 0;
    while (rsp_vld == '0 && n < 40) begin
      tick();
      n++;
    end
    check({tag, " response seen"}, 32'(rsp_vld != '0), 32'd1);
    at = cyc;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int t0;
    int at;
    int seen;
    logic [31:0] fr_x [4];
    logic [15:0] fr_y [4];

    fr_x[0] = 32'd0;          fr_y[0] = 16'd0;
    fr_x[1] = 32'hFFFF_FFFF;  fr_y[1] = 16'd65535;
    fr_x[2] = 32'hFFFF_FFFE;  fr_y[2] = 16'd65535;
    fr_x[3] = 32'd65536;      fr_y[3] = 16'd256;

    // ---------------- reset state ----------------
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("reset rsp_vld", 32'(rsp_vld), 32'd0);
    check("reset rsp_id", 32'(rsp_id), 32'd0);
    check("reset rsp_y", 32'(rsp_y), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset req_rdy", 32'(req_rdy), 32'd0);
    check("reset sq_x_vld", 32'(sq_x_vld), 32'd0);
    check("reset sq_x", sq_x, 32'd0);

    // ---------------- round robin, all requesting ----------------
    req_x[31:0]   = 32'd1;
    req_x[63:32]  = 32'd4;
    req_x[95:64]  = 32'd9;
    req_x[127:96] = 32'd16;
    req_vld = 4'b1111;
    t0 = cyc;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("rr grant", 32'(req_rdy), 32'd1 << (k % 4));
      check("rr sq_x", sq_x, 32'((k % 4 + 1) * (k % 4 + 1)));
      tick();
    end
    req_vld = '0;
    #1;
    check("idle sq_x", sq_x, 32'd0);
    check("idle sq_x_vld", 32'(sq_x_vld), 32'd0);
    wait_rsp("rr", at);
    check("rr latency", 32'(at - t0), 32'd17);
    for (int k = 0; k < 8; k++) begin
      check("rr rsp_vld", 32'(rsp_vld), 32'd1 << (k % 4));
      check("rr rsp_id", 32'(rsp_id), 32'(k % 4));
      check("rr rsp_y", 32'(rsp_y), 32'(k % 4 + 1));
      tick();
    end
    check("rr rsp_vld after burst", 32'(rsp_vld), 32'd0);
    check("rr err", 32'(err), 32'd0);

    // ---------------- single request ----------------
    req_x[95:64] = 32'd144;
    req_vld = 4'b0100;
    #1;
    check("single grant", 32'(req_rdy), 32'b0100);
    check("single sq_x", sq_x, 32'd144);
    t0 = cyc;
    tick();
    req_vld = '0;
    wait_rsp("single", at);
    check("single latency", 32'(at - t0), 32'd17);
    check("single rsp_vld", 32'(rsp_vld), 32'b0100);
    check("single rsp_id", 32'(rsp_id), 32'd2);
    check("single rsp_y", 32'(rsp_y), 32'd12);
    tick();
    check("single pulse width", 32'(rsp_vld), 32'd0);

    // ---------------- pointer wrap / skip (pointer now 3) ----------------
    req_x[31:0]   = 32'd25;
    req_x[95:64]  = 32'd49;
    req_x[127:96] = 32'd36;
    req_vld = 4'b0101;
    #1;
    check("wrap grant a", 32'(req_rdy), 32'b0001);
    check("wrap sq_x a", sq_x, 32'd25);
    t0 = cyc;
    tick();
    check("wrap grant b", 32'(req_rdy), 32'b0100);
    check("wrap sq_x b", sq_x, 32'd49);
    tick();
    check("wrap grant c", 32'(req_rdy), 32'b0001);
    check("wrap sq_x c", sq_x, 32'd25);
    tick();
    req_vld = '0;
    #1;
    check("wrap idle sq_x", sq_x, 32'd0);
    check("wrap idle req_rdy", 32'(req_rdy), 32'd0);
    wait_rsp("wrap", at);
    check("wrap latency", 32'(at - t0), 32'd17);
    check("wrap rsp a vld", 32'(rsp_vld), 32'b0001);
    check("wrap rsp a y", 32'(rsp_y), 32'd5);
    tick();
    check("wrap rsp b vld", 32'(rsp_vld), 32'b0100);
    check("wrap rsp b id", 32'(rsp_id), 32'd2);
    check("wrap rsp b y", 32'(rsp_y), 32'd7);
    tick();
    check("wrap rsp c vld", 32'(rsp_vld), 32'b0001);
    check("wrap rsp c y", 32'(rsp_y), 32'd5);
    tick();
    check("wrap rsp end", 32'(rsp_vld), 32'd0);

    // ---------------- full rate, boundary operands ----------------
    req_vld = 4'b0010;
    t0 = cyc;
    for (int k = 0; k < 4; k++) begin
      req_x[63:32] = fr_x[k];
      #1;
      check("full grant", 32'(req_rdy), 32'b0010);
      tick();
    end
    req_vld = '0;
    wait_rsp("full", at);
    check("full latency", 32'(at - t0), 32'd17);
    for (int k = 0; k < 4; k++) begin
      check("full rsp_vld", 32'(rsp_vld), 32'b0010);
      check("full rsp_id", 32'(rsp_id), 32'd1);
      check("full rsp_y", 32'(rsp_y), 32'(fr_y[k]));
      tick();
    end
    check("full err", 32'(err), 32'd0);

    // ---------------- reset mid-flight ----------------
    req_x[95:64] = 32'd4;
    req_vld = 4'b0100;
    for (int k = 0; k < 8; k++) tick();
    req_vld = '0;
    for (int k = 0; k < 5; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst err", 32'(err), 32'd0);
    check("midrst rsp_vld", 32'(rsp_vld), 32'd0);
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      if (rsp_vld != '0) seen++;
      tick();
    end
    check("midrst stale responses", 32'(seen), 32'd0);
    check("midrst err after", 32'(err), 32'd0);
    req_x[31:0] = 32'd81;
    req_vld = 4'b1111;
    #1;
    check("midrst pointer at 0", 32'(req_rdy), 32'b0001);
    t0 = cyc;
    tick();
    req_vld = '0;
    wait_rsp("post-reset", at);
    check("post-reset latency", 32'(at - t0), 32'd17);
    check("post-reset rsp_vld", 32'(rsp_vld), 32'b0001);
    check("post-reset rsp_id", 32'(rsp_id), 32'd0);
    check("post-reset rsp_y", 32'(rsp_y), 32'd9);
    tick();

    // ---------------- latency mismatch (isqrt latency 15) ----------------
    for (int k = 0; k < 3; k++) tick();
    model_lat = 15;
    req_x[31:0] = 32'd100;
    req_vld = 4'b0001;
    t0 = cyc;
    tick();
    req_vld = '0;
    while (cyc < t0 + 15) tick();
    check("mismatch err before", 32'(err), 32'd0);
    tick();
    check("mismatch err set", 32'(err), 32'd1);
    tick();
    check("mismatch routed by tag", 32'(rsp_vld), 32'b0001);
    check("mismatch err held", 32'(err), 32'd1);
    for (int k = 0; k < 10; k++) tick();
    check("mismatch err sticky", 32'(err), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_lat = 16;
    check("mismatch err cleared", 32'(err), 32'd0);
    for (int k = 0; k < 20; k++) tick();
    check("mismatch err stays clear", 32'(err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
